// File: rtl/pp_carry_accum_reg.sv
// Partial-product / carry shift-accumulator for the sequential Booth multiplier datapath.
// Latency: product and done appear one cycle after the last accepted step.
// Backpressure: none; rows are taken whenever busy and step_valid, and dropped otherwise.
module pp_carry_accum_reg #(
    parameter  int WIDTH = 32,
    parameter  int SHIFT = 4,
    localparam int PP_W  = WIDTH + SHIFT - 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 step_valid,
    input  logic [PP_W-1:0]      pp_din,
    input  logic [PP_W-1:0]      carry_din,
    output logic [2*WIDTH-1:0]   pp_dout,
    output logic [2*WIDTH-1:0]   carry_dout,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic                 product_valid
);
    localparam int STEPS = WIDTH / SHIFT;
    localparam int CNT_W = $clog2(STEPS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   step_cnt;
    logic [2*WIDTH-1:0] pp_q;
    logic [2*WIDTH-1:0] carry_q;
    logic [2*WIDTH-1:0] pp_shift;
    logic [2*WIDTH-1:0] carry_shift;
    logic               accept;
    logic               finish;

    // New row lands on top; previously retired low bits slide down by SHIFT.
    generate
        if (SHIFT < WIDTH) begin : g_keep_low
            assign pp_shift    = {pp_din[PP_W-1], pp_din, pp_q[WIDTH-1:SHIFT]};
            assign carry_shift = {carry_din, 1'b0, carry_q[WIDTH-1:SHIFT]};
        end else begin : g_no_low
            assign pp_shift    = {pp_din[PP_W-1], pp_din};
            assign carry_shift = {carry_din, 1'b0};
        end
    endgenerate

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        finish    = 1'b0;
        if (start) begin
            state_nxt = ACCUM;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = IDLE;
                end
                ACCUM: begin
                    if (step_valid) begin
                        accept = 1'b1;
                        if (step_cnt == LAST_CNT) begin
                            state_nxt = FINISH;
                        end
                    end
                end
                FINISH: begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pp_q          <= '0;
            carry_q       <= '0;
            step_cnt      <= '0;
            product       <= '0;
            product_valid <= 1'b0;
            done          <= 1'b0;
        end else if (start) begin
            // product keeps its last value; only the valid flag is withdrawn
            pp_q          <= '0;
            carry_q       <= '0;
            step_cnt      <= '0;
            product_valid <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= finish;
            if (accept) begin
                pp_q     <= pp_shift;
                carry_q  <= carry_shift;
                step_cnt <= step_cnt + CNT_W'(1);
            end
            if (finish) begin
                product       <= pp_q + carry_q;
                product_valid <= 1'b1;
            end
        end
    end

    assign pp_dout    = pp_q;
    assign carry_dout = carry_q;
    assign busy       = (state == ACCUM);

endmodule

// File: tb/tb_pp_carry_accum_reg.sv
// Bench for pp_carry_accum_reg: cycle table on an 8-bit instance, async reset sequence,
// and a Booth radix-16 carry-save driver on the default 32-bit instance with a product scoreboard.
module tb_pp_carry_accum_reg;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        s8_start, s8_vld;
    logic [10:0] s8_pp, s8_cy;
    logic [15:0] o8_pp, o8_cy, o8_prod;
    logic        o8_busy, o8_done, o8_pv;

    logic        s32_start, s32_vld;
    logic [34:0] s32_pp, s32_cy;
    logic [63:0] o32_pp, o32_cy, o32_prod;
    logic        o32_busy, o32_done, o32_pv;

    pp_carry_accum_reg #(.WIDTH(8), .SHIFT(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(s8_start), .step_valid(s8_vld),
        .pp_din(s8_pp), .carry_din(s8_cy), .pp_dout(o8_pp), .carry_dout(o8_cy),
        .busy(o8_busy), .done(o8_done), .product(o8_prod), .product_valid(o8_pv)
    );

    pp_carry_accum_reg dut32 (
        .clk(clk), .rst_n(rst_n), .start(s32_start), .step_valid(s32_vld),
        .pp_din(s32_pp), .carry_din(s32_cy), .pp_dout(o32_pp), .carry_dout(o32_cy),
        .busy(o32_busy), .done(o32_done), .product(o32_prod), .product_valid(o32_pv)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Scoreboards: expected products queued when the final step is driven.
    typedef struct {
        logic [63:0] prod;
        int          due;
    } exp32_t;

    logic [15:0] sb8_q[$];
    exp32_t      sb32_q[$];
    exp32_t      e32;
    int          cyc_cnt = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always @(negedge clk) begin
        if (o8_done) begin
            chk("sb8_pending", 64'(sb8_q.size() != 0), 64'd1);
            if (sb8_q.size() != 0) chk("sb8_product", 64'(o8_prod), 64'(sb8_q.pop_front()));
        end
        if (o32_done) begin
            chk("sb32_pending", 64'(sb32_q.size() != 0), 64'd1);
            if (sb32_q.size() != 0) begin
                e32 = sb32_q.pop_front();
                chk("sb32_product", o32_prod, e32.prod);
                chk("sb32_latency", 64'(cyc_cnt), 64'(e32.due));
            end
        end
    end

    typedef struct {
        logic        start;
        logic        vld;
        logic [10:0] pp;
        logic [10:0] cy;
        logic [15:0] e_pp;
        logic [15:0] e_cy;
        logic [15:0] e_prod;
        logic        e_busy;
        logic        e_done;
        logic        e_pv;
        logic        push;
        logic [15:0] sb_val;
    } vec8_t;

    function automatic vec8_t v(input logic st, input logic vl, input logic [10:0] p,
                                input logic [10:0] c, input logic [15:0] ep, input logic [15:0] ec,
                                input logic [15:0] epr, input logic eb, input logic ed,
                                input logic ev, input logic ps, input logic [15:0] sb);
        vec8_t r;
        r.start = st;  r.vld = vl;   r.pp = p;       r.cy = c;
        r.e_pp = ep;   r.e_cy = ec;  r.e_prod = epr;
        r.e_busy = eb; r.e_done = ed; r.e_pv = ev;
        r.push = ps;   r.sb_val = sb;
        return r;
    endfunction

    // One complete Booth radix-16 multiply through the 32-bit instance.
    task automatic run32(input logic signed [31:0] a, input logic signed [31:0] b);
        logic [32:0] bx;
        longint      upp, uc, t, c, d, ppv;
        exp32_t      e;
        bx  = {b, 1'b0};
        upp = 0;
        uc  = 0;
        s32_start = 1'b1;
        @(posedge clk); #1;
        s32_start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            d = longint'(bx[4*k]) + longint'(bx[4*k+1]) + 2 * longint'(bx[4*k+2])
              + 4 * longint'(bx[4*k+3]) - 8 * longint'(bx[4*k+4]);
            t = upp + uc + d * longint'(a);
            c = (t >= 0) ? longint'($urandom_range(0, 20'hFFFFF)) : 0;
            ppv = t - 2 * c;
            s32_pp  = ppv[34:0];
            s32_cy  = c[34:0];
            s32_vld = 1'b1;
            upp = ppv >>> 4;
            uc  = c >>> 3;
            if (k == 7) begin
                e.prod = 64'(longint'(a) * longint'(b));
                e.due  = cyc_cnt + 2;
                sb32_q.push_back(e);
            end
            @(posedge clk); #1;
        end
        s32_vld = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    vec8_t tbl[20];

    initial begin
        logic [31:0] ra, rb;
        rst_n = 1'b0;
        s8_start = 1'b0;  s8_vld = 1'b0;  s8_pp = '0;  s8_cy = '0;
        s32_start = 1'b0; s32_vld = 1'b0; s32_pp = '0; s32_cy = '0;

        //            st    vld   pp       cy       e_pp      e_cy      e_prod    bsy   done  pv    push  sb
        tbl[0]  = v(1'b0, 1'b1, 11'h7FF, 11'h7FF, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        tbl[1]  = v(1'b1, 1'b0, 11'h000, 11'h000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        tbl[2]  = v(1'b0, 1'b1, 11'h015, 11'h003, 16'h0150, 16'h0060, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        tbl[3]  = v(1'b0, 1'b0, 11'h123, 11'h456, 16'h0150, 16'h0060, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        tbl[4]  = v(1'b0, 1'b0, 11'h123, 11'h456, 16'h0150, 16'h0060, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        tbl[5]  = v(1'b0, 1'b0, 11'h123, 11'h456, 16'h0150, 16'h0060, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        tbl[6]  = v(1'b0, 1'b1, 11'h402, 11'h001, 16'hC025, 16'h0026, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'hC04B);
        tbl[7]  = v(1'b0, 1'b1, 11'h333, 11'h111, 16'hC025, 16'h0026, 16'hC04B, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
        tbl[8]  = v(1'b0, 1'b1, 11'h555, 11'h222, 16'hC025, 16'h0026, 16'hC04B, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
        tbl[9]  = v(1'b1, 1'b0, 11'h000, 11'h000, 16'h0000, 16'h0000, 16'hC04B, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        tbl[10] = v(1'b0, 1'b1, 11'h015, 11'h003, 16'h0150, 16'h0060, 16'hC04B, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        tbl[11] = v(1'b1, 1'b1, 11'h7FF, 11'h7FF, 16'h0000, 16'h0000, 16'hC04B, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        tbl[12] = v(1'b0, 1'b1, 11'h015, 11'h003, 16'h0150, 16'h0060, 16'hC04B, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        tbl[13] = v(1'b0, 1'b1, 11'h402, 11'h001, 16'hC025, 16'h0026, 16'hC04B, 1'b0, 1'b0, 1'b0, 1'b1, 16'hC04B);
        tbl[14] = v(1'b0, 1'b0, 11'h000, 11'h000, 16'hC025, 16'h0026, 16'hC04B, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
        tbl[15] = v(1'b1, 1'b0, 11'h000, 11'h000, 16'h0000, 16'h0000, 16'hC04B, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        tbl[16] = v(1'b0, 1'b1, 11'h000, 11'h000, 16'h0000, 16'h0000, 16'hC04B, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        tbl[17] = v(1'b0, 1'b1, 11'h7FF, 11'h001, 16'hFFF0, 16'h0020, 16'hC04B, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0010);
        tbl[18] = v(1'b0, 1'b0, 11'h000, 11'h000, 16'hFFF0, 16'h0020, 16'h0010, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
        tbl[19] = v(1'b0, 1'b0, 11'h000, 11'h000, 16'hFFF0, 16'h0020, 16'h0010, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);

        #12;
        chk("reset_pp8",   64'(o8_pp),   64'h0);
        chk("reset_cy8",   64'(o8_cy),   64'h0);
        chk("reset_busy8", 64'(o8_busy), 64'h0);
        chk("reset_pv8",   64'(o8_pv),   64'h0);
        chk("reset_prod32", o32_prod,    64'h0);
        chk("reset_busy32", 64'(o32_busy), 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 20; i++) begin
            s8_start = tbl[i].start;
            s8_vld   = tbl[i].vld;
            s8_pp    = tbl[i].pp;
            s8_cy    = tbl[i].cy;
            if (tbl[i].push) sb8_q.push_back(tbl[i].sb_val);
            @(posedge clk); #1;
            chk($sformatf("row%0d_pp", i),   64'(o8_pp),   64'(tbl[i].e_pp));
            chk($sformatf("row%0d_cy", i),   64'(o8_cy),   64'(tbl[i].e_cy));
            chk($sformatf("row%0d_prod", i), 64'(o8_prod), 64'(tbl[i].e_prod));
            chk($sformatf("row%0d_busy", i), 64'(o8_busy), 64'(tbl[i].e_busy));
            chk($sformatf("row%0d_done", i), 64'(o8_done), 64'(tbl[i].e_done));
            chk($sformatf("row%0d_pv", i),   64'(o8_pv),   64'(tbl[i].e_pv));
        end
        s8_start = 1'b0;
        s8_vld   = 1'b0;

        // Asynchronous reset in the middle of an accumulation.
        s8_start = 1'b1;
        @(posedge clk); #1;
        s8_start = 1'b0;
        s8_vld = 1'b1; s8_pp = 11'h015; s8_cy = 11'h003;
        @(posedge clk); #1;
        s8_vld = 1'b0;
        chk("midrst_busy_before", 64'(o8_busy), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_pp",   64'(o8_pp),   64'h0);
        chk("midrst_cy",   64'(o8_cy),   64'h0);
        chk("midrst_prod", 64'(o8_prod), 64'h0);
        chk("midrst_busy", 64'(o8_busy), 64'h0);
        chk("midrst_done", 64'(o8_done), 64'h0);
        chk("midrst_pv",   64'(o8_pv),   64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("postrst_busy", 64'(o8_busy), 64'h0);
        chk("postrst_pv",   64'(o8_pv),   64'h0);

        run32(32'sd3, 32'sd5);
        run32(-32'sd1, -32'sd1);
        run32(32'sh7FFF_FFFF, 32'sh8000_0000);
        run32(32'sh8000_0001, 32'sh8000_0000);
        run32(32'sh8000_0001, 32'sh7FFF_FFFF);
        run32(32'sd0, -32'sd12345);
        for (int n = 0; n < 1000; n++) begin
            ra = $urandom;
            rb = $urandom;
            if (ra == 32'h8000_0000) ra = 32'h8000_0001;
            run32(ra, rb);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("sb8_drained",  64'(sb8_q.size()),  64'h0);
        chk("sb32_drained", 64'(sb32_q.size()), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
